// File: rtl/dmi_pkg.sv
// Shared encodings for the DMI command sequencer: op codes, response codes
// and the sequencer FSM state type.
package dmi_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] RSP_OK   = 2'd0;
  localparam logic [1:0] RSP_FAIL = 2'd2;
  localparam logic [1:0] RSP_BUSY = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  // Exit word seen by the harness: LSB flags "exited", upper bits carry the code.
  function automatic logic [31:0] exit_word(input logic [30:0] code);
    return {code, 1'b1};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on rdata whenever
// the FIFO is not empty. Push while full is accepted only with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmi_sequencer.sv
// Buffers host DMI commands and issues them one at a time on the DMI port,
// with busy retry, response timeout and an intercepted exit-word address.
module dmi_sequencer
  import dmi_pkg::*;
#(
  parameter int               ADDR_W    = 7,
  parameter int               DATA_W    = 32,
  parameter int               CMD_DEPTH = 4,
  parameter int               MAX_RETRY = 3,
  parameter int               TIMEOUT   = 1024,
  parameter logic [ADDR_W-1:0] EXIT_ADDR = 7'h7F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_resp,
  output logic [DATA_W-1:0] rsp_data,
  output logic              debug_req_valid,
  input  logic              debug_req_ready,
  output logic [ADDR_W-1:0] debug_req_bits_addr,
  output logic [1:0]        debug_req_bits_op,
  output logic [DATA_W-1:0] debug_req_bits_data,
  input  logic              debug_resp_valid,
  output logic              debug_resp_ready,
  input  logic [1:0]        debug_resp_bits_resp,
  input  logic [DATA_W-1:0] debug_resp_bits_data,
  output logic [31:0]       exit
);

  localparam int CMD_W = ADDR_W + 2 + DATA_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int RW    = $clog2(MAX_RETRY + 2);

  logic [CMD_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [1:0]        head_op;
  logic [DATA_W-1:0] head_data;

  state_t            state;
  state_t            state_next;
  logic              load_cmd;
  logic              rsp_load;
  logic [1:0]        rsp_code;
  logic [DATA_W-1:0] rsp_value;
  logic              retry_inc;
  logic              exit_wr;

  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic [RW-1:0]     retry;
  logic [TW-1:0]     timer;
  logic [1:0]        rsp_code_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [31:0]       exit_q;

  assign cmd_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_addr, cmd_op, cmd_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_addr = head[CMD_W-1 -: ADDR_W];
  assign head_op   = head[DATA_W +: 2];
  assign head_data = head[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_cmd   = 1'b0;
    rsp_load   = 1'b0;
    rsp_code   = RSP_OK;
    rsp_value  = '0;
    retry_inc  = 1'b0;
    exit_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_op == OP_READ || (head_op == OP_WRITE && head_addr != EXIT_ADDR)) begin
            load_cmd   = 1'b1;
            state_next = REQ;
          end else begin
            // nop, reserved op and the exit write complete locally
            rsp_load   = 1'b1;
            rsp_code   = (head_op == OP_RSVD) ? RSP_FAIL : RSP_OK;
            exit_wr    = (head_op == OP_WRITE);
            state_next = RESP;
          end
        end
      end
      REQ: begin
        if (debug_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (debug_resp_valid) begin
          case (debug_resp_bits_resp)
            RSP_OK: begin
              rsp_load   = 1'b1;
              rsp_code   = RSP_OK;
              rsp_value  = (req_op == OP_READ) ? debug_resp_bits_data : '0;
              state_next = RESP;
            end
            RSP_BUSY: begin
              if (retry < RW'(MAX_RETRY)) begin
                retry_inc  = 1'b1;
                state_next = REQ;
              end else begin
                rsp_load   = 1'b1;
                rsp_code   = RSP_BUSY;
                state_next = RESP;
              end
            end
            default: begin
              rsp_load   = 1'b1;
              rsp_code   = RSP_FAIL;
              state_next = RESP;
            end
          endcase
        end else if (timer == TW'(TIMEOUT - 1)) begin
          rsp_load   = 1'b1;
          rsp_code   = RSP_FAIL;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched request, counters and response/exit registers; all cleared so
  // every output reads zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr   <= '0;
      req_op     <= '0;
      req_data   <= '0;
      retry      <= '0;
      timer      <= '0;
      rsp_code_q <= '0;
      rsp_data_q <= '0;
      exit_q     <= '0;
    end else begin
      if (load_cmd) begin
        req_addr <= head_addr;
        req_op   <= head_op;
        req_data <= head_data;
      end
      if (load_cmd)       retry <= '0;
      else if (retry_inc) retry <= retry + 1'b1;
      // Leaving WAIT (including a busy retry through REQ) restarts the timer.
      timer <= (state == WAIT) ? timer + 1'b1 : '0;
      if (rsp_load) begin
        rsp_code_q <= rsp_code;
        rsp_data_q <= rsp_value;
      end
      if (exit_wr) exit_q <= exit_word(head_data[30:0]);
    end
  end

  assign debug_req_valid     = (state == REQ);
  assign debug_req_bits_addr = req_addr;
  assign debug_req_bits_op   = req_op;
  assign debug_req_bits_data = req_data;
  assign debug_resp_ready    = (state == WAIT);
  assign rsp_valid           = (state == RESP);
  assign rsp_resp            = rsp_code_q;
  assign rsp_data            = rsp_data_q;
  assign exit                = exit_q;

endmodule

// File: tb/tb_dmi_sequencer.sv
// Directed bench for dmi_sequencer: a table of single-command transactions
// against a scripted DMI responder, plus hand-written multi-cycle sequences.
module tb_dmi_sequencer;
  import dmi_pkg::*;

  localparam int         TIMEOUT   = 1024;
  localparam logic [6:0] EXIT_ADDR = 7'h7F;
  localparam int         BUDGET    = 3000;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        debug_req_valid;
  logic        debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid;
  logic        debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;
  logic [31:0] exit;

  dmi_sequencer #(
    .ADDR_W(7), .DATA_W(32), .CMD_DEPTH(4), .MAX_RETRY(3),
    .TIMEOUT(TIMEOUT), .EXIT_ADDR(EXIT_ADDR)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .debug_req_valid(debug_req_valid), .debug_req_ready(debug_req_ready),
    .debug_req_bits_addr(debug_req_bits_addr), .debug_req_bits_op(debug_req_bits_op),
    .debug_req_bits_data(debug_req_bits_data),
    .debug_resp_valid(debug_resp_valid), .debug_resp_ready(debug_resp_ready),
    .debug_resp_bits_resp(debug_resp_bits_resp), .debug_resp_bits_data(debug_resp_bits_data),
    .exit(exit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Responder configuration, written only by the main sequence.
  logic [4:0][1:0] scr_cur;
  int              script_base;
  bit              no_resp;
  int              resp_delay;
  logic [31:0]     resp_rdata;
  bit              model_clr;

  // Responder state, written only by the responder process.
  int          req_total = 0;
  logic [6:0]  log_addr [0:63];
  logic [1:0]  log_op   [0:63];
  logic [31:0] log_data [0:63];
  bit          pending;
  bit          took;
  int          cnt;
  int          idx;
  logic [1:0]  pend_code;

  always begin
    @(negedge clk);
    #1;
    if (model_clr) begin
      debug_resp_valid     = 1'b0;
      debug_resp_bits_resp = 2'd0;
      debug_resp_bits_data = 32'd0;
      pending = 1'b0;
      took    = 1'b0;
    end else begin
      if (took) begin
        debug_resp_valid = 1'b0;
        took = 1'b0;
      end
      if (debug_req_valid && debug_req_ready) begin
        idx = req_total - script_base;
        if (req_total < 64) begin
          log_addr[req_total] = debug_req_bits_addr;
          log_op[req_total]   = debug_req_bits_op;
          log_data[req_total] = debug_req_bits_data;
        end
        pend_code = (idx >= 0 && idx < 5) ? scr_cur[idx] : 2'd0;
        req_total = req_total + 1;
        pending   = !no_resp;
        cnt       = resp_delay;
      end else if (pending) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          pending = 1'b0;
          debug_resp_valid     = 1'b1;
          debug_resp_bits_resp = pend_code;
          debug_resp_bits_data = resp_rdata;
        end
      end
      if (debug_resp_valid && debug_resp_ready) took = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d);
    int k;
    cmd_valid = 1'b1; cmd_addr = a; cmd_op = o; cmd_data = d;
    k = 0;
    while (!cmd_ready && k < BUDGET) begin @(negedge clk); k++; end
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < BUDGET) begin @(negedge clk); k++; end
  endtask

  task automatic get_rsp(input string nm, input logic [1:0] er, input logic [31:0] ed);
    wait_rsp();
    chk({nm, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_resp"}, {30'd0, rsp_resp}, {30'd0, er});
    chk({nm, "_data"}, rsp_data, ed);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [6:0]      addr;
    logic [1:0]      op;
    logic [31:0]     data;
    logic [4:0][1:0] scr;
    logic [31:0]     rdata;
    logic [1:0]      exp_resp;
    logic [31:0]     exp_data;
    int              exp_reqs;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int base;
    int k;
    vecs[0] = '{7'h10, OP_WRITE, 32'hDEADBEEF, 10'h000, 32'hA5A5A5A5, RSP_OK,   32'd0,        1};
    vecs[1] = '{7'h10, OP_READ,  32'h00000000, 10'h000, 32'hDEADBEEF, RSP_OK,   32'hDEADBEEF, 1};
    vecs[2] = '{7'h11, OP_READ,  32'h00000000, 10'h03F, 32'h12345678, RSP_OK,   32'h12345678, 4};
    vecs[3] = '{7'h12, OP_READ,  32'h00000000, 10'h0FF, 32'h87654321, RSP_BUSY, 32'd0,        4};
    vecs[4] = '{7'h05, OP_WRITE, 32'h0000BEEF, 10'h002, 32'h11111111, RSP_FAIL, 32'd0,        1};
    vecs[5] = '{7'h06, OP_READ,  32'h00000000, 10'h001, 32'h22222222, RSP_FAIL, 32'd0,        1};
    vecs[6] = '{7'h07, OP_NOP,   32'h00000000, 10'h000, 32'h33333333, RSP_OK,   32'd0,        0};
    vecs[7] = '{7'h08, OP_RSVD,  32'h00000000, 10'h000, 32'h44444444, RSP_FAIL, 32'd0,        0};
    vecs[8] = '{7'h09, OP_WRITE, 32'h00C0FFEE, 10'h003, 32'h55555555, RSP_OK,   32'd0,        2};
    vecs[9] = '{EXIT_ADDR, OP_WRITE, 32'h0000002A, 10'h000, 32'h66666666, RSP_OK, 32'd0,      0};

    reset = 1'b1; model_clr = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_op = '0; cmd_data = '0;
    rsp_ready = 1'b0; debug_req_ready = 1'b1;
    no_resp = 1'b0; resp_delay = 2; resp_rdata = '0; scr_cur = '0; script_base = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, debug_req_valid}, 32'd0);
    chk("rst_resp_ready", {31'd0, debug_resp_ready}, 32'd0);
    chk("rst_exit", exit, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    model_clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      scr_cur = vecs[i].scr;
      resp_rdata = vecs[i].rdata;
      script_base = req_total;
      base = req_total;
      push(vecs[i].addr, vecs[i].op, vecs[i].data);
      get_rsp($sformatf("v%0d", i), vecs[i].exp_resp, vecs[i].exp_data);
      chk($sformatf("v%0d_reqs", i), req_total - base, vecs[i].exp_reqs);
      if (vecs[i].exp_reqs > 0) begin
        chk($sformatf("v%0d_req_addr", i), {25'd0, log_addr[base]}, {25'd0, vecs[i].addr});
        chk($sformatf("v%0d_req_op", i), {30'd0, log_op[base]}, {30'd0, vecs[i].op});
        chk($sformatf("v%0d_req_data", i), log_data[base], vecs[i].data);
        chk($sformatf("v%0d_last_addr", i), {25'd0, log_addr[base + vecs[i].exp_reqs - 1]},
            {25'd0, vecs[i].addr});
      end
      @(negedge clk);
    end
    chk("exit_word", exit, 32'h00000055);
    scr_cur = '0;

    // Response arriving on the final timer cycle must win over the timeout.
    resp_delay = TIMEOUT; resp_rdata = 32'h0BADCAFE; script_base = req_total;
    push(7'h22, OP_READ, 32'd0);
    get_rsp("edge_resp", RSP_OK, 32'h0BADCAFE);
    resp_delay = 2;

    // Silent DMI: timeout after exactly TIMEOUT cycles, then the queued write runs.
    no_resp = 1'b1; base = req_total; script_base = req_total;
    push(7'h33, OP_READ, 32'd0);
    push(7'h34, OP_WRITE, 32'h00000001);
    k = 0;
    while (!(debug_req_valid && debug_req_ready) && k < 50) begin @(negedge clk); k++; end
    chk("to_req_seen", {31'd0, debug_req_valid}, 32'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) no_resp = 1'b0;
    end while (!rsp_valid && k < BUDGET);
    chk("to_wait_cycles", k - 1, TIMEOUT);
    get_rsp("to_resp", RSP_FAIL, 32'd0);
    get_rsp("to_next", RSP_OK, 32'd0);
    chk("to_reqs", req_total - base, 2);
    chk("to_next_addr", {25'd0, log_addr[base + 1]}, 32'h34);

    // Stall the DMI side: four entries buffered plus one latched.
    debug_req_ready = 1'b0; base = req_total; script_base = req_total;
    for (int j = 0; j < 5; j++) push(7'(j + 1), OP_WRITE, 32'h100 + j);
    chk("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("fill_no_req", req_total - base, 0);
    debug_req_ready = 1'b1;
    for (int j = 0; j < 5; j++) get_rsp($sformatf("fill%0d", j), RSP_OK, 32'd0);
    chk("fill_reqs", req_total - base, 5);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("fill%0d_addr", j), {25'd0, log_addr[base + j]}, j + 1);
      chk($sformatf("fill%0d_wdata", j), log_data[base + j], 32'h100 + j);
    end
    chk("fill_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Response held while the host stalls.
    resp_rdata = 32'hCAFEF00D; script_base = req_total;
    push(7'h50, OP_READ, 32'd0);
    wait_rsp();
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("hold%0d_valid", j), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("hold%0d_resp", j), {30'd0, rsp_resp}, 32'd0);
      chk($sformatf("hold%0d_data", j), rsp_data, 32'hCAFEF00D);
      @(negedge clk);
    end
    get_rsp("hold_final", RSP_OK, 32'hCAFEF00D);
    chk("exit_kept", exit, 32'h00000055);

    // Asynchronous reset in the middle of WAIT with a second command queued.
    no_resp = 1'b1; script_base = req_total;
    push(7'h44, OP_READ, 32'd0);
    push(7'h45, OP_WRITE, 32'h00000099);
    k = 0;
    while (!debug_resp_ready && k < 50) begin @(negedge clk); k++; end
    chk("mid_in_wait", {31'd0, debug_resp_ready}, 32'd1);
    #2;
    reset = 1'b1; model_clr = 1'b1;
    #1;
    chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("mid_rsp_data", rsp_data, 32'd0);
    chk("mid_req_valid", {31'd0, debug_req_valid}, 32'd0);
    chk("mid_req_addr", {25'd0, debug_req_bits_addr}, 32'd0);
    chk("mid_req_op", {30'd0, debug_req_bits_op}, 32'd0);
    chk("mid_req_data", debug_req_bits_data, 32'd0);
    chk("mid_resp_ready", {31'd0, debug_resp_ready}, 32'd0);
    chk("mid_exit", exit, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_clr = 1'b0; no_resp = 1'b0;
    base = req_total;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("post%0d_rsp_valid", j), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("post%0d_req_valid", j), {31'd0, debug_req_valid}, 32'd0);
      @(negedge clk);
    end
    resp_rdata = 32'h600DF00D; script_base = req_total;
    push(7'h46, OP_READ, 32'd0);
    get_rsp("post_read", RSP_OK, 32'h600DF00D);
    chk("post_reqs", req_total - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmi_sequencer.md
Name: dmi_sequencer

Overview:
- Synthesizable successor to the tied-off debug transport stub: accepts DMI commands from a host-side valid/ready port, buffers them, and issues them one at a time on the DMI request channel.
- Retries busy responses, enforces a response timeout, and returns one response per command.
- Intercepts writes to a reserved address to drive the simulation `exit` word.
- Sits between the test harness/host bridge and the debug module's DMI port.

Parameters:
- ADDR_W, 7, DMI address width
- DATA_W, 32, DMI data width
- CMD_DEPTH, 4, command FIFO entries (power of two, ≥2)
- MAX_RETRY, 3, reissues allowed after a busy (resp=3) response
- TIMEOUT, 1024, cycles to wait for a DMI response before failing
- EXIT_ADDR, 7'h7F, intercepted address for the exit word

Ports:
- clk, in, 1, sole clock
- reset, in, 1, asynchronous active-high reset
- cmd_valid, in, 1, host command valid
- cmd_ready, out, 1, command FIFO not full
- cmd_addr, in, ADDR_W, command address
- cmd_op, in, 2, 0=nop, 1=read, 2=write, 3=reserved
- cmd_data, in, DATA_W, write data
- rsp_valid, out, 1, response valid
- rsp_ready, in, 1, host accepts response
- rsp_resp, out, 2, 0=ok, 2=failed, 3=busy-exhausted
- rsp_data, out, DATA_W, read data (0 for non-reads)
- debug_req_valid, out, 1, DMI request valid
- debug_req_ready, in, 1, DMI request ready
- debug_req_bits_addr, out, ADDR_W, DMI address
- debug_req_bits_op, out, 2, DMI op
- debug_req_bits_data, out, DATA_W, DMI data
- debug_resp_valid, in, 1, DMI response valid
- debug_resp_ready, out, 1, DMI response ready
- debug_resp_bits_resp, in, 2, DMI response code
- debug_resp_bits_data, in, DATA_W, DMI response data
- exit, out, 32, 0 while running; {code[30:0],1} once exit is written

Behaviour:
- Reset (async, active-high): FIFO empty, FSM=IDLE, counters 0.
  - All outputs 0 except cmd_ready=1.
  - exit=0 is cleared only by reset.
- Command FIFO:
  - Push on cmd_valid&&cmd_ready.
  - Pop when IDLE dispatches the head entry.
  - Push and pop in the same cycle when full is legal; occupancy stays unchanged.
  - cmd_ready=0 only when the FIFO holds CMD_DEPTH entries.
- IDLE, FIFO non-empty, head selects the path:
  - op=0 or 3, or op=2 with addr==EXIT_ADDR: no DMI transaction; go to RESP.
    - For the exit write: exit<={cmd_data[30:0],1'b1} and rsp_resp=0.
    - For op=3: rsp_resp=2.
  - Otherwise: latch the command, clear retry and timer counters, go to REQ.
- REQ:
  - debug_req_valid=1 with the latched fields.
  - On debug_req_ready, go to WAIT.
- WAIT:
  - debug_resp_ready=1; timer increments every cycle.
  - On debug_resp_valid, by debug_resp_bits_resp:
    - 0: go to RESP with rsp_resp=0; rsp_data=resp data for reads, else 0.
    - 3 with retry<MAX_RETRY: retry++, back to REQ (same fields, timer cleared).
    - 3 with retry==MAX_RETRY: go to RESP with rsp_resp=3.
    - Other codes: go to RESP with rsp_resp=2.
  - Timer reaching TIMEOUT-1 without a response: go to RESP with rsp_resp=2. The response and the final timer cycle arriving together: the response wins.
- RESP:
  - rsp_valid=1; fields are held stable until rsp_ready.
  - Then go to IDLE. A new dispatch can occur on the following cycle, so there is 1 cycle minimum between responses.
- debug_resp_ready=0 outside WAIT. Stray DMI responses are never consumed and never produce rsp_valid.
- Exactly one DMI transaction is outstanding at a time. Responses are returned in command order.
- Reset mid-transaction drops all state. The DMI side must tolerate an abandoned request.

Decomposition:
- Shared package dmi_pkg:
  - DMI op encodings: NOP, READ, WRITE.
  - Response codes: OK=0, FAIL=2, BUSY=3.
  - FSM state enum: IDLE, REQ, WAIT, RESP.
- One sub-module: sync_fifo (parametrised width/depth; full/empty; simultaneous push/pop), instantiated with width ADDR_W+2+DATA_W.

Test Plan:
- Write then read to address 0x10 (data 0xDEADBEEF); DMI responds ok after 2 cycles -> two responses, resp=0; read rsp_data=0xDEADBEEF; each DMI request appears exactly once.
- Read with DMI returning busy 3 times then ok (MAX_RETRY=3) -> 4 DMI requests, one response, resp=0; busy 4 times -> 4 requests, resp=3.
- DMI never responds -> after exactly TIMEOUT cycles in WAIT, rsp_valid with resp=2; the next queued command then proceeds.
- Push 5 commands back-to-back with debug_req_ready=0 (CMD_DEPTH=4) -> cmd_ready drops after 4 entries are buffered (plus 1 latched); release -> all 5 complete in order.
- Write 0x2A to EXIT_ADDR -> no DMI request; exit=0x55; resp=0.
- Hold rsp_ready=0 for 10 cycles -> rsp fields stable; assert reset mid-WAIT -> all outputs return to reset values immediately (async).
